filter_stream_driver: RTL
=========================

Name: filter_stream_driver

Overview:
- Frame-level driver for the pixel-filter interface (POSX/POSY/READY/RDEN in, WREN/result out) used by the image-processing filters.
- Scans a source frame buffer in raster order and presents one pixel per accepted cycle to a filter.
- Collects the filter's WREN-qualified results and writes them linearly into a destination frame buffer.
- Latency-agnostic toward the filter: completion is detected by counting WRENs, not by assuming a pipeline depth.

Parameters:
WIDTH, 640, frame width in pixels (1..4095)
HEIGHT, 480, frame height in lines (1..4095)
AW, 19, source/destination address width; must satisfy 2^AW >= WIDTH*HEIGHT

Ports:
CLK  in  1  system clock
RST  in  1  synchronous reset, active-low
START  in  1  one-cycle pulse; begins a frame when idle
HOLD  in  1  back-pressure; while 1, no new source reads are issued
BUSY  out  1  frame in progress
DONE  out  1  one-cycle pulse at frame completion
ERR  out  1  sticky protocol error flag
SRC_RDEN  out  1  source buffer read strobe
SRC_ADDR  out  AW  source read address
SRC_DATA  in  24  {R,G,B} read data; valid exactly 1 cycle after SRC_RDEN
POSX  out  12  x coordinate of the presented pixel
POSY  out  12  y coordinate of the presented pixel
READY  out  1  presented pixel valid this cycle
RDEN  in  1  filter acceptance (filters tie RDEN to READY)
PIX_R, PIX_G, PIX_B  out  8 each  presented pixel; SRC_DATA[23:16], [15:8], [7:0] passed combinationally
WREN  in  1  filter result valid
RES_R, RES_G, RES_B  in  8 each  filter result
DST_WREN  out  1  destination write strobe
DST_ADDR  out  AW  destination write address
DST_DATA  out  24  {RES_R,RES_G,RES_B}

Behaviour:
- Reset (RST=0 at a clock edge): state IDLE; all counters 0; BUSY, DONE, ERR, SRC_RDEN, READY, DST_WREN = 0; SRC_ADDR, DST_ADDR, DST_DATA, POSX, POSY = 0. Reset mid-frame aborts immediately with no DONE.
- States:
  - IDLE: START -> RUN; ERR cleared, counters cleared.
  - RUN: issue reads; after the read for address WIDTH*HEIGHT-1 -> DRAIN.
  - DRAIN: wait for remaining WRENs.
  - FIN: one cycle, DONE=1, then -> IDLE.
- BUSY = 1 in RUN and DRAIN. START outside IDLE is ignored.
- Issue (RUN): SRC_RDEN = !HOLD. On each issue, SRC_ADDR increments by 1 (linear, starting at 0); the x/y counters advance in raster order: x wraps WIDTH-1 -> 0 and y increments; the last pixel is (WIDTH-1, HEIGHT-1).
- Present: READY, POSX and POSY are registered copies of the issue strobe and the issued x/y, so READY is high exactly 1 cycle after SRC_RDEN, aligned with SRC_DATA. READY falls the cycle after an un-issued (HOLD) cycle; gaps are allowed.
- A cycle with READY=1 and RDEN=0 sets ERR. The pixel is lost and the frame still completes on the WREN count.
- Collect: each WREN=1 cycle registers DST_WREN=1, DST_DATA = results, and DST_ADDR = the output count, then increments the output count. Result: 1-cycle latency from WREN to DST_WREN, addresses 0..WIDTH*HEIGHT-1 in order.
- WREN in IDLE or FIN, or beyond WIDTH*HEIGHT results, sets ERR and produces no DST_WREN.
- Completion: final WREN at cycle t -> last DST_WREN at t+1 -> FIN (DONE=1, BUSY=0) at t+2.
- WREN and issue in the same cycle are independent; both proceed.
- HOLD has no effect on collection.
- ERR stays set until the next accepted START or reset.

Test Plan:
- WIDTH=4, HEIGHT=2, HOLD=0, 2-cycle filter model (RDEN=READY, WREN 2 cycles after READY), START at cycle 0 -> SRC_RDEN cycles 1-8 with addresses 0-7; READY cycles 2-9 with POSX 0,1,2,3,0,1,2,3 and POSY 0,0,0,0,1,1,1,1; DST_WREN cycles 5-12 with addresses 0-7, each DST_DATA equal to the model result; DONE at cycle 13; BUSY high for cycles 1-12; ERR=0.
- Same frame with HOLD=1 on cycles 3-4 -> issues at 1, 2, 5-10; READY gap at cycles 4-5; no pixel duplicated or skipped; DONE at cycle 15.
- Filter latency 6 -> state stays DRAIN after the last issue until the 8th WREN; DONE exactly 2 cycles after the final WREN.
- START pulsed at cycle 4 of a running frame -> ignored; counters unaffected; exactly 8 DST writes and one DONE.
- RST=0 for 1 cycle mid-frame (after 3 issues) -> all outputs 0 next cycle; no DONE; a following START scans from address 0.
- WREN pulsed while IDLE -> ERR=1 and no DST_WREN; next START clears ERR; that frame completes with ERR=0.

Source files
------------

// File: rtl/filter_stream_driver.sv
// -----------------------------------------------------------------------------
// filter_stream_driver
//
// Frame-level driver for a pixel filter. It scans a source frame buffer in
// raster order, presents one pixel per issued read to the filter, and writes
// the filter's WREN-qualified results linearly into a destination buffer.
// Completion is detected by counting results rather than by assuming a fixed
// filter pipeline depth.
//
// Ports:
//   CLK, RST           clock and synchronous active-low reset
//   START, HOLD        frame start pulse (honoured only when idle), read back-pressure
//   BUSY, DONE, ERR    frame in progress, completion pulse, sticky protocol error
//   SRC_RDEN/ADDR/DATA source buffer read port (data valid one cycle after RDEN)
//   POSX, POSY, READY  coordinates and valid strobe of the presented pixel
//   PIX_R/G/B          presented pixel, taken straight from SRC_DATA
//   RDEN               filter acceptance of the presented pixel
//   WREN, RES_R/G/B    filter result strobe and result
//   DST_WREN/ADDR/DATA destination buffer write port
// -----------------------------------------------------------------------------
module filter_stream_driver #(
   parameter int WIDTH  = 640,
   parameter int HEIGHT = 480,
   parameter int AW     = 19
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          START,
   input  logic          HOLD,
   output logic          BUSY,
   output logic          DONE,
   output logic          ERR,
   output logic          SRC_RDEN,
   output logic [AW-1:0] SRC_ADDR,
   input  logic [23:0]   SRC_DATA,
   output logic [11:0]   POSX,
   output logic [11:0]   POSY,
   output logic          READY,
   input  logic          RDEN,
   output logic [7:0]    PIX_R,
   output logic [7:0]    PIX_G,
   output logic [7:0]    PIX_B,
   input  logic          WREN,
   input  logic [7:0]    RES_R,
   input  logic [7:0]    RES_G,
   input  logic [7:0]    RES_B,
   output logic          DST_WREN,
   output logic [AW-1:0] DST_ADDR,
   output logic [23:0]   DST_DATA
);

   localparam int unsigned   NPIX      = WIDTH * HEIGHT;
   localparam logic [AW-1:0] LAST_ADDR = AW'(NPIX - 1);
   // One bit wider than an address so the count can reach NPIX itself.
   localparam logic [AW:0]   NPIX_CNT  = (AW + 1)'(NPIX);
   localparam logic [11:0]   X_LAST    = 12'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      FIN
   } state_t;

   state_t      state;
   logic [11:0] x;
   logic [11:0] y;
   logic [AW:0] out_cnt;

   logic issue;
   logic last_issue;
   logic accept_start;
   logic collect;
   logic wren_err;
   logic lost_pixel;

   // HOLD must stop a read in the same cycle, so the read strobe is a
   // decode of the state register and HOLD rather than a flop.
   assign issue        = (state == RUN) && !HOLD;
   assign last_issue   = issue && (SRC_ADDR == LAST_ADDR);
   assign accept_start = (state == IDLE) && START;
   assign SRC_RDEN     = issue;

   // Results are taken only while a frame is active and still short of a
   // full frame; anything else is a protocol error and is dropped.
   assign collect    = WREN && ((state == RUN) || (state == DRAIN)) && (out_cnt != NPIX_CNT);
   assign wren_err   = WREN && !collect;
   assign lost_pixel = READY && !RDEN;

   // Pixel data arrives one cycle after the read, aligned with READY.
   assign PIX_R = SRC_DATA[23:16];
   assign PIX_G = SRC_DATA[15:8];
   assign PIX_B = SRC_DATA[7:0];

   // NOTE: reset is synchronous, so RST only takes effect at a clock edge and
   // combinational decodes of state still show the pre-reset value until then.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         state    <= IDLE;
         BUSY     <= 1'b0;
         DONE     <= 1'b0;
         ERR      <= 1'b0;
         SRC_ADDR <= '0;
         x        <= '0;
         y        <= '0;
         out_cnt  <= '0;
         READY    <= 1'b0;
         POSX     <= '0;
         POSY     <= '0;
         DST_WREN <= 1'b0;
         DST_ADDR <= '0;
         DST_DATA <= '0;
      end else begin
         // Presentation stage: registered copy of the issue and its coordinates.
         READY <= issue;
         if (issue) begin
            POSX     <= x;
            POSY     <= y;
            SRC_ADDR <= SRC_ADDR + AW'(1);
            if (x == X_LAST) begin
               x <= '0;
               y <= y + 12'd1;
            end else begin
               x <= x + 12'd1;
            end
         end

         // Collection stage: one result in, one destination write out.
         DST_WREN <= collect;
         if (collect) begin
            DST_ADDR <= out_cnt[AW-1:0];
            DST_DATA <= {RES_R, RES_G, RES_B};
            out_cnt  <= out_cnt + (AW + 1)'(1);
         end

         // A new frame clears the flag, but an error in that same cycle wins.
         ERR <= (ERR && !accept_start) || lost_pixel || wren_err;

         case (state)
            IDLE: begin
               if (START) begin
                  state    <= RUN;
                  BUSY     <= 1'b1;
                  SRC_ADDR <= '0;
                  x        <= '0;
                  y        <= '0;
                  out_cnt  <= '0;
               end
            end
            RUN: begin
               if (last_issue) state <= DRAIN;
            end
            DRAIN: begin
               // Finish once every result has been written, whatever the
               // filter latency turned out to be.
               if (out_cnt == NPIX_CNT) begin
                  state <= FIN;
                  BUSY  <= 1'b0;
                  DONE  <= 1'b1;
               end
            end
            FIN: begin
               state <= IDLE;
               DONE  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
